// File: rtl/keypad_matrix_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, full-scan debounce,
// single-key encoding and a valid/ack event port with overflow indication.
module keypad_matrix_scanner #(
    parameter int SCAN_TICKS     = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overflow
);

    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {CLS_NONE, CLS_KEY, CLS_GHOST} cls_t;
    typedef enum logic {IDLE, PRESSED} state_t;

    function automatic logic [4:0] count_ones(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
        return n;
    endfunction

    function automatic logic [3:0] encode(input logic [15:0] v);
        logic [3:0] k;
        k = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) k = 4'(i);
        return k;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    logic [3:0]        row_p0, row_p1;
    logic [TICK_W-1:0] tick;
    logic [1:0]        col;
    logic [15:0]       snapshot, snap_next;
    logic              slot_end, scan_end;
    cls_t              scan_cls, cand_cls, cand_cls_d;
    logic [3:0]        scan_code, cand_code, cand_code_d;
    logic [CNT_W-1:0]  match, match_d;
    state_t            state, state_d;
    logic [3:0]        stable_code, stable_code_d;
    logic              fire;

    // Stage p0/p1: two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= row_in;
            row_p1 <= row_p0;
        end
    end

    assign slot_end = (tick == TICK_LAST);
    assign scan_end = slot_end && (col == 2'd3);
    assign col_out  = ~(4'b0001 << col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick     <= '0;
            col      <= '0;
            snapshot <= '0;
        end else begin
            tick <= slot_end ? '0 : tick + TICK_W'(1);
            if (slot_end) begin
                col      <= col + 2'd1;
                snapshot <= snap_next;
            end
        end
    end

    // The column-3 samples are merged combinationally so the boundary sees a complete scan
    always_comb begin
        snap_next = snapshot;
        if (slot_end) begin
            for (int r = 0; r < 4; r++) snap_next[{r[1:0], col}] = ~row_p1[r];
        end
    end

    always_comb begin
        scan_code = encode(snap_next);
        case (count_ones(snap_next))
            5'd0:    scan_cls = CLS_NONE;
            5'd1:    scan_cls = CLS_KEY;
            default: scan_cls = CLS_GHOST;
        endcase
    end

    always_comb begin
        cand_cls_d  = cand_cls;
        cand_code_d = cand_code;
        match_d     = match;
        if (scan_cls == CLS_GHOST) begin
            cand_cls_d  = CLS_GHOST;
            cand_code_d = '0;
            match_d     = '0;
        end else if (scan_cls == cand_cls && scan_code == cand_code) begin
            match_d = sat_inc(match);
        end else begin
            cand_cls_d  = scan_cls;
            cand_code_d = scan_code;
            match_d     = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_cls  <= CLS_NONE;
            cand_code <= '0;
            match     <= '0;
        end else if (scan_end) begin
            cand_cls  <= cand_cls_d;
            cand_code <= cand_code_d;
            match     <= match_d;
        end
    end

    always_comb begin
        state_d       = state;
        stable_code_d = stable_code;
        fire          = 1'b0;
        if (scan_end && match_d == CNT_MAX && cand_cls_d != CLS_GHOST) begin
            case (state)
                IDLE: begin
                    if (cand_cls_d == CLS_KEY) begin
                        state_d       = PRESSED;
                        stable_code_d = cand_code_d;
                        fire          = 1'b1;
                    end
                end
                PRESSED: begin
                    if (cand_cls_d == CLS_NONE) begin
                        state_d = IDLE;
                    end else if (cand_code_d != stable_code) begin
                        stable_code_d = cand_code_d;
                        fire          = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stable_code <= '0;
        end else begin
            state       <= state_d;
            stable_code <= stable_code_d;
        end
    end

    assign key_held = (state == PRESSED);

    // An ack in the same cycle as a new event frees the slot, so the event is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (fire) begin
                if (!key_valid || key_ack) begin
                    key_code  <= stable_code_d;
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural keypad model
// (SCAN_TICKS=4, DEBOUNCE_SCANS=3, one scan = 16 cycles).
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        key_held;
    logic        overflow;
    logic [15:0] pressed = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          events = 0;
    int          e0;

    keypad_matrix_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
        .key_held(key_held), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Keypad: row r is pulled low when a pressed key in row r sits on the driven column
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
    end

    always @(posedge key_valid) events++;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic scans(input int n);
        cycles(16 * n);
    endtask

    task automatic test_reset;
        n_cmp++; if (col_out !== 4'b1110) begin n_bad++; $display("FAIL reset_col: got %b expected %b", col_out, 4'b1110); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL reset_held: got %b expected 0", key_held); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        n_cmp++; if (key_code !== 4'd0) begin n_bad++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    endtask

    task automatic test_scan;
        logic [3:0] exp;
        for (int k = 1; k <= 16; k++) begin
            cycles(1);
            exp = ~(4'b0001 << ((k / 4) % 4));
            n_cmp++; if (col_out !== exp) begin n_bad++; $display("FAIL scan_col[%0d]: got %b expected %b", k, col_out, exp); end
        end
    endtask

    task automatic test_press_release;
        pressed = 16'h1 << 9;
        scans(2);
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL press_early_valid: got %b expected 0", key_valid); end
        scans(1);
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL press_valid: got %b expected 1", key_valid); end
        n_cmp++; if (key_code !== 4'd9) begin n_bad++; $display("FAIL press_code: got %0d expected 9", key_code); end
        n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL press_held: got %b expected 1", key_held); end
        key_ack = 1'b1;
        cycles(1);
        key_ack = 1'b0;
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL ack_valid: got %b expected 0", key_valid); end
        n_cmp++; if (key_code !== 4'd9) begin n_bad++; $display("FAIL ack_code: got %0d expected 9", key_code); end
        cycles(15);
        pressed = '0;
        scans(2);
        n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL release_early_held: got %b expected 1", key_held); end
        scans(1);
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL release_held: got %b expected 0", key_held); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid: got %b expected 0", key_valid); end
    endtask

    task automatic test_bounce;
        e0 = events;
        pressed = 16'h1 << 9;
        scans(2);
        pressed = '0;
        scans(1);
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL bounce_gap_valid: got %b expected 0", key_valid); end
        pressed = 16'h1 << 9;
        scans(2);
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL bounce_early_valid: got %b expected 0", key_valid); end
        scans(1);
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL bounce_valid: got %b expected 1", key_valid); end
        n_cmp++; if (key_code !== 4'd9) begin n_bad++; $display("FAIL bounce_code: got %0d expected 9", key_code); end
        n_cmp++; if (events !== e0 + 1) begin n_bad++; $display("FAIL bounce_events: got %0d expected %0d", events - e0, 1); end
        key_ack = 1'b1;
        cycles(1);
        key_ack = 1'b0;
        cycles(15);
        pressed = '0;
        scans(3);
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL bounce_release_held: got %b expected 0", key_held); end
    endtask

    task automatic test_overflow;
        pressed = 16'h1;
        scans(3);
        n_cmp++; if (key_valid !== 1'b1 || key_code !== 4'd0) begin n_bad++; $display("FAIL ovf_first: got valid=%b code=%0d expected valid=1 code=0", key_valid, key_code); end
        pressed = '0;
        scans(3);
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL ovf_release_held: got %b expected 0", key_held); end
        pressed = 16'h1 << 15;
        scans(3);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
        n_cmp++; if (key_code !== 4'd0) begin n_bad++; $display("FAIL ovf_code: got %0d expected 0", key_code); end
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid: got %b expected 1", key_valid); end
        n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL ovf_held: got %b expected 1", key_held); end
        cycles(1);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_one_cycle: got %b expected 0", overflow); end
        cycles(15);
        pressed = '0;
        scans(3);
        pressed = 16'h1 << 15;
        scans(2);
        cycles(15);
        key_ack = 1'b1;
        cycles(1);
        key_ack = 1'b0;
        n_cmp++; if (key_code !== 4'd15) begin n_bad++; $display("FAIL ackev_code: got %0d expected 15", key_code); end
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL ackev_valid: got %b expected 1", key_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ackev_ovf: got %b expected 0", overflow); end
        key_ack = 1'b1;
        cycles(1);
        key_ack = 1'b0;
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL ackev_clear: got %b expected 0", key_valid); end
        cycles(14);
        pressed = '0;
        scans(3);
    endtask

    task automatic test_ghost_and_reset;
        e0 = events;
        pressed = (16'h1 << 0) | (16'h1 << 5);
        scans(4);
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL ghost_valid: got %b expected 0", key_valid); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL ghost_held: got %b expected 0", key_held); end
        n_cmp++; if (events !== e0) begin n_bad++; $display("FAIL ghost_events: got %0d expected 0", events - e0); end
        pressed = 16'h1 << 3;
        scans(1);
        cycles(8);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (col_out !== 4'b1110) begin n_bad++; $display("FAIL midrst_col: got %b expected %b", col_out, 4'b1110); end
        n_cmp++; if (key_code !== 4'd0) begin n_bad++; $display("FAIL midrst_code: got %0d expected 0", key_code); end
        n_cmp++; if (key_valid !== 1'b0 || key_held !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: got valid=%b held=%b ovf=%b expected 0 0 0", key_valid, key_held, overflow); end
        pressed = '0;
        cycles(2);
        rst_n = 1'b1;
        n_cmp++; if (col_out !== 4'b1110) begin n_bad++; $display("FAIL postrst_col: got %b expected %b", col_out, 4'b1110); end
        scans(3);
        n_cmp++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin n_bad++; $display("FAIL postrst_flags: got valid=%b held=%b expected 0 0", key_valid, key_held); end
        n_cmp++; if (events !== e0) begin n_bad++; $display("FAIL postrst_events: got %0d expected 0", events - e0); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_scan();
        test_press_release();
        test_bounce();
        test_overflow();
        test_ghost_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
